// File: rtl/cdc_test_pkg.sv
// ============================================================================
// cdc_test_pkg : shared state encoding and data-stream seed for the CDC lab
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdc_test_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SEND  = ST_SEND,
    S_GAP   = ST_GAP,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  // First word the checker expects after reset; both sides must agree.
  localparam int NEXT_DATA_RST = 1;

endpackage

`default_nettype wire

// File: rtl/seq_gap_timer.sv
// ============================================================================
// seq_gap_timer : loadable down-counter timing the idle gap between words
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             expired
);

  logic [GAP_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - GAP_W'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/cdc_test_sequencer.sv
// ============================================================================
// cdc_test_sequencer : drives the incrementing word stream into the data
//                      checker and turns its failure pulses into a verdict
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_test_sequencer
  import cdc_test_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  input  logic [GAP_W-1:0]   gap,
  input  logic               inject_err,
  input  logic               failure,
  output logic               data_en,
  output logic [WIDTH-1:0]   data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] sent_count,
  output logic [COUNT_W-1:0] err_count
);

  state_t             r_state;
  logic [COUNT_W-1:0] r_num_words;
  logic [GAP_W-1:0]   r_gap;
  logic [WIDTH-1:0]   r_next_data;
  logic               r_pending;

  logic               w_accept;
  logic               w_last;
  logic               w_emit;
  logic               w_inj;
  logic               w_timer_load;
  logic               w_gap_expired;
  logic               w_fail_cnt;
  logic [COUNT_W-1:0] w_err_next;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last       = (sent_count == r_num_words);
  // Outputs are registered, so the word is produced on the edge entering SEND.
  assign w_emit       = (w_accept && (num_words != '0))
                      || ((r_state == S_SEND) && !w_last && (r_gap == '0))
                      || ((r_state == S_GAP) && w_gap_expired);
  assign w_inj        = r_pending | inject_err;
  assign w_timer_load = (r_state == S_SEND) && !w_last && (r_gap != '0);
  assign w_fail_cnt   = failure && (err_count != '1)
                      && ((r_state == S_SEND) || (r_state == S_GAP) || (r_state == S_DRAIN));
  assign w_err_next   = w_fail_cnt ? (err_count + COUNT_W'(1)) : err_count;

  seq_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_timer_load),
    .value   (r_gap - GAP_W'(1)),
    .expired (w_gap_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num_words <= '0;
      r_gap       <= '0;
      r_next_data <= WIDTH'(NEXT_DATA_RST);
      r_pending   <= 1'b0;
      data_en     <= 1'b0;
      data        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      sent_count  <= '0;
      err_count   <= '0;
    end else begin
      done    <= 1'b0;
      data_en <= w_emit;

      if (w_emit) begin
        data        <= r_next_data ^ {{(WIDTH-1){1'b0}}, w_inj};
        r_next_data <= r_next_data + WIDTH'(1);
        r_pending   <= 1'b0;
      end else begin
        r_pending   <= w_inj;
      end

      if (w_accept) begin
        sent_count <= COUNT_W'(w_emit);
        err_count  <= '0;
      end else begin
        if (w_emit) sent_count <= sent_count + COUNT_W'(1);
        err_count <= w_err_next;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_words <= num_words;
            r_gap       <= gap;
            busy        <= 1'b1;
            if (num_words == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              r_state <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_last)               r_state <= S_DRAIN;
          else if (r_gap != '0)     r_state <= S_GAP;
        end
        S_GAP: begin
          if (w_gap_expired) r_state <= S_SEND;
        end
        S_DRAIN: begin
          // Include the failure for the last word, sampled this cycle.
          r_state <= S_DONE;
          done    <= 1'b1;
          pass    <= (w_err_next == '0);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
